// File: rtl/if_fetch_unit_pkg.sv
// Shared IF-stage types and constants: bus widths, zero instruction/address,
// reset and stall encodings, fetch FSM states and the pc+inst entry type.
package if_fetch_unit_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      ZERO_INST      = '0;
    localparam logic [INST_ADDR_W-1:0] ZERO_INST_ADDR = '0;
    localparam logic                   RST_ENABLE     = 1'b1;
    localparam logic                   STALL_NO       = 1'b0;

    typedef enum logic [1:0] {
        IF_IDLE  = 2'd0,
        IF_FETCH = 2'd1,
        IF_KILL  = 2'd2
    } ifState_t;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetchEntry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge port; the fetch unit is the master.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic                   imem_req;
    logic [INST_ADDR_W-1:0] imem_addr;
    logic                   imem_ack;
    logic [INST_W-1:0]      imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_fetch_unit_skid_slot.sv
// One-entry holding slot for a fetched instruction that the stalled output
// register cannot take yet. Flush wins over load, load wins over take.
module if_skid_slot
    import if_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_take,
    input  logic        i_flush,
    input  fetchEntry_t i_entry,
    output logic        o_full,
    output fetchEntry_t o_entry
);

    logic        r_full;
    fetchEntry_t r_entry;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || i_flush) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full <= 1'b1;
        end else if (i_take) begin
            r_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_entry <= i_entry;
        end
    end

    assign o_full  = r_full;
    assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC generation, single-outstanding req/ack fetch FSM, output
// register for IF/ID with a skid slot behind it, and branch redirect.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [INST_ADDR_W-1:0] PC_STEP  = 32'd4
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_stall,
    input  logic                   i_branch_flag,
    input  logic [INST_ADDR_W-1:0] i_branch_target,
    if_fetch_unit_if.master        imem,
    output logic [INST_ADDR_W-1:0] o_if_pc,
    output logic [INST_W-1:0]      o_if_inst,
    output logic                   o_if_valid
);

    ifState_t               r_state;
    ifState_t               w_nextState;
    logic [INST_ADDR_W-1:0] r_fetchPc;
    logic [INST_ADDR_W-1:0] r_killAddr;
    logic [INST_ADDR_W-1:0] r_outPc;
    logic [INST_W-1:0]      r_outInst;
    logic                   r_outValid;

    logic        w_consume;
    logic        w_redirect;
    logic        w_ack;
    logic        w_accept;
    logic        w_skidFull;
    logic        w_skidLoad;
    logic        w_skidTake;
    logic        w_skidFullNext;
    fetchEntry_t w_skidEntry;
    fetchEntry_t w_ackEntry;

    // Data is only taken in FETCH; a redirect in the same cycle discards it.
    assign w_consume      = (i_stall == STALL_NO);
    assign w_redirect     = i_branch_flag && w_consume;
    assign w_ack          = imem.imem_ack && (r_state == IF_FETCH);
    assign w_accept       = w_ack && !w_redirect;
    assign w_skidTake     = w_consume && w_skidFull;
    assign w_skidLoad     = w_accept && (!w_consume || w_skidFull);
    assign w_skidFullNext = !w_redirect && (w_skidLoad || (w_skidFull && !w_skidTake));
    assign w_ackEntry     = '{pc: r_fetchPc, inst: imem.imem_rdata};

    if_skid_slot u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skidLoad),
        .i_take  (w_skidTake),
        .i_flush (w_redirect),
        .i_entry (w_ackEntry),
        .o_full  (w_skidFull),
        .o_entry (w_skidEntry)
    );

    assign imem.imem_req  = (r_state != IF_IDLE);
    assign imem.imem_addr = (r_state == IF_KILL) ? r_killAddr : r_fetchPc;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= IF_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fetching pauses while the skid holds an instruction, so the unit never
    // has more than two undelivered instructions.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IF_IDLE: begin
                if (!w_skidFullNext) begin
                    w_nextState = IF_FETCH;
                end
            end
            IF_FETCH: begin
                if (imem.imem_ack) begin
                    w_nextState = w_skidFullNext ? IF_IDLE : IF_FETCH;
                end else if (w_redirect) begin
                    w_nextState = IF_KILL;
                end
            end
            IF_KILL: begin
                if (imem.imem_ack) begin
                    w_nextState = IF_FETCH;
                end
            end
            default: w_nextState = IF_IDLE;
        endcase
    end

    // The old address is kept on the bus until the abandoned request is ack'd.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_fetchPc  <= RESET_PC;
            r_killAddr <= RESET_PC;
        end else begin
            if (r_state == IF_FETCH && !imem.imem_ack && w_redirect) begin
                r_killAddr <= r_fetchPc;
            end
            if (w_redirect) begin
                r_fetchPc <= i_branch_target;
            end else if (w_accept) begin
                r_fetchPc <= r_fetchPc + PC_STEP;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_outPc    <= ZERO_INST_ADDR;
            r_outInst  <= ZERO_INST;
            r_outValid <= 1'b0;
        end else if (w_consume) begin
            if (w_redirect) begin
                r_outInst  <= ZERO_INST;
                r_outValid <= 1'b0;
            end else if (w_skidFull) begin
                r_outPc    <= w_skidEntry.pc;
                r_outInst  <= w_skidEntry.inst;
                r_outValid <= 1'b1;
            end else if (w_accept) begin
                r_outPc    <= w_ackEntry.pc;
                r_outInst  <= w_ackEntry.inst;
                r_outValid <= 1'b1;
            end else begin
                r_outInst  <= ZERO_INST;
                r_outValid <= 1'b0;
            end
        end
    end

    assign o_if_pc    = r_outPc;
    assign o_if_inst  = r_outInst;
    assign o_if_valid = r_outValid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a latency-programmable instruction
// memory that returns 0xA000_0000 | address for every fetch.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branchFlag = 1'b0;
    logic [31:0] branchTarget = 32'h0;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        ifValid;

    int memLatency = 0;
    int waitCnt = 0;
    int checks = 0;
    int failures = 0;

    if_fetch_unit_if imemBus();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (32'd4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_stall         (stall),
        .i_branch_flag   (branchFlag),
        .i_branch_target (branchTarget),
        .imem            (imemBus),
        .o_if_pc         (ifPc),
        .o_if_inst       (ifInst),
        .o_if_valid      (ifValid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instFor(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Memory: acks a request once it has waited memLatency cycles.
    initial begin
        imemBus.imem_ack = 1'b0;
        imemBus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                imemBus.imem_ack = 1'b0;
                waitCnt = 0;
            end else if (imemBus.imem_req) begin
                if (waitCnt >= memLatency) begin
                    imemBus.imem_ack = 1'b1;
                    imemBus.imem_rdata = instFor(imemBus.imem_addr);
                    waitCnt = 0;
                end else begin
                    imemBus.imem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                imemBus.imem_ack = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic stallIn, input logic branchIn,
                                 input logic [31:0] targetIn);
        @(negedge clk);
        rst = rstIn;
        stall = stallIn;
        branchFlag = branchIn;
        branchTarget = targetIn;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic checkPresented(input string tag, input logic [31:0] pc);
        checkOutput({tag, "_valid"}, {31'b0, ifValid}, 32'd1);
        checkOutput({tag, "_pc"}, ifPc, pc);
        checkOutput({tag, "_inst"}, ifInst, instFor(pc));
    endtask

    task automatic checkBubble(input string tag);
        checkOutput({tag, "_valid"}, {31'b0, ifValid}, 32'd0);
        checkOutput({tag, "_inst"}, ifInst, 32'h0);
    endtask

    task automatic checkBus(input string tag, input logic req, input logic [31:0] addr);
        checkOutput({tag, "_req"}, {31'b0, imemBus.imem_req}, {31'b0, req});
        if (req) begin
            checkOutput({tag, "_addr"}, imemBus.imem_addr, addr);
        end
    endtask

    initial begin
        // Reset values, then zero-wait sequential streaming.
        memLatency = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h40);
        checkBubble("rst");
        checkOutput("rst_pc", ifPc, 32'h0);
        checkBus("rst", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("t1_first");
        checkBus("t1_first", 1'b1, 32'h0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkPresented($sformatf("t1_seq%0d", k), 32'(4 * k));
            checkBus($sformatf("t1_seq%0d", k), 1'b1, 32'(4 * k + 4));
        end

        // Three-cycle memory wait: request held, bubbles presented.
        memLatency = 3;
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkBubble($sformatf("t2_wait%0d", i));
            checkBus($sformatf("t2_wait%0d", i), 1'b1, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t2_done", 32'h0);
        checkBus("t2_done", 1'b1, 32'h4);
        memLatency = 0;

        // Stall: output frozen at 0x10, 0x14 parked in skid, request drops.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkPresented("t3_pre", 32'h10);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
            checkPresented($sformatf("t3_stall%0d", i), 32'h10);
            checkBus($sformatf("t3_stall%0d", i), 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t3_rel0", 32'h14);
        checkBus("t3_rel0", 1'b1, 32'h18);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t3_rel1", 32'h18);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t3_rel2", 32'h1C);

        // Redirect to 0x100 while 0x0C is outstanding.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        checkPresented("t4_pre", 32'h08);
        checkBus("t4_pre", 1'b1, 32'h0C);
        memLatency = 2;
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
        checkBubble("t4_br");
        checkBus("t4_br", 1'b1, 32'h0C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("t4_kill");
        checkBus("t4_kill", 1'b1, 32'h0C);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("t4_drop");
        checkBus("t4_drop", 1'b1, 32'h100);
        memLatency = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t4_tgt", 32'h100);
        checkBus("t4_tgt", 1'b1, 32'h104);

        // Redirect under stall is ignored.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
        checkPresented("t5_hold", 32'h08);
        checkBus("t5_hold", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t5_seq0", 32'h0C);
        checkBus("t5_seq0", 1'b1, 32'h10);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t5_seq1", 32'h10);

        // Reset with stall, branch and a full skid.
        doReset();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkPresented("t6_skid", 32'h08);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
        checkBubble("t6_rst");
        checkOutput("t6_rst_pc", ifPc, 32'h0);
        checkBus("t6_rst", 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkBubble("t6_first");
        checkBus("t6_first", 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t6_seq0", 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkPresented("t6_seq1", 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
